// File: rtl/mac_package.sv
// -----------------------------------------------------------------------------
// mac_package
// Shared types for the MAC operand aligner:
//   ALIGNER_CNT_W    - width of the len/cnt/stall_cnt fields in the ctrl/flags
//                      structs. The aligner's CNT_WIDTH parameter defaults to it.
//   aligner_state_t  - aligner FSM encoding (IDLE, RUN, DONE).
//   ctrl_aligner_t   - job control: 1-cycle start pulse and the beat count len.
//   flags_aligner_t  - status: busy, done pulse, beat counter, stall counter.
// -----------------------------------------------------------------------------
package mac_package;

    localparam int unsigned ALIGNER_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aligner_state_t;

    typedef struct packed {
        logic                     start;
        logic [ALIGNER_CNT_W-1:0] len;
    } ctrl_aligner_t;

    typedef struct packed {
        logic                     busy;
        logic                     done;
        logic [ALIGNER_CNT_W-1:0] cnt;
        logic [ALIGNER_CNT_W-1:0] stall_cnt;
    } flags_aligner_t;

endpackage : mac_package

// File: rtl/mac_aligner_fifo.sv
// -----------------------------------------------------------------------------
// mac_aligner_fifo
// Small synchronous FIFO used to buffer one operand stream of the aligner.
// The head entry is presented combinationally on data_o.
//
// Parameters
//   DATA_WIDTH - entry width
//   FIFO_DEPTH - number of entries, power of two, >= 2
// Ports
//   clk_i, rst_ni - clock and asynchronous active-low reset
//   enable_i      - low freezes pointers, occupancy and storage
//   clear_i       - synchronous flush, wins over push and pop
//   push_i/data_i - write request and write data
//   pop_i         - read request (head advances)
//   data_o        - current head entry
//   full_o        - occupancy == FIFO_DEPTH
//   empty_o       - occupancy == 0
// -----------------------------------------------------------------------------
module mac_aligner_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic                  clear_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [OCC_W-1:0]      occ_q;
    logic                  push_ok;
    logic                  pop_ok;

    assign full_o  = (occ_q == OCC_W'(FIFO_DEPTH));
    assign empty_o = (occ_q == '0);
    assign data_o  = mem[rd_ptr_q];

    // A push into a full FIFO is only legal when the head leaves on the same
    // edge; the written slot is then the one being vacated.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    // Pointers are PTR_W bits wide, so increments wrap modulo FIFO_DEPTH.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else if (enable_i) begin
            if (clear_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                occ_q    <= '0;
            end else begin
                if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                unique case ({push_ok, pop_ok})
                    2'b10:   occ_q <= occ_q + OCC_W'(1);
                    2'b01:   occ_q <= occ_q - OCC_W'(1);
                    default: occ_q <= occ_q;
                endcase
            end
        end
    end

    // Storage carries data only; it needs no reset.
    always_ff @(posedge clk_i) begin
        if (enable_i && !clear_i && push_ok) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

endmodule : mac_aligner_fifo

// File: rtl/mac_operand_aligner.sv
// -----------------------------------------------------------------------------
// mac_operand_aligner
// Joins three independent operand streams (a, b, c) into one operand beat
// {c, b, a} for the MAC engine. Each stream has its own FIFO so operands can
// prefetch while no job is running. A job is started by ctrl_i.start with
// ctrl_i.len beats; op_last_o marks the final beat and flags_o.done pulses for
// one cycle after it.
//
// Build option
//   MAC_ALIGNER_STATS_EN - when defined, flags_o.stall_cnt counts RUN cycles in
//                          which a beat is offered but the engine is not ready
//                          (saturating). Otherwise stall_cnt is tied to zero.
//
// Parameters
//   DATA_WIDTH - per-operand width
//   FIFO_DEPTH - per-operand buffer depth (power of two, >= 2)
//   CNT_WIDTH  - beat counter / length width
// Ports
//   clk_i, rst_ni             - clock, asynchronous active-low reset
//   test_mode_i               - test mode, no functional effect
//   enable_i                  - low freezes all state, ready/valid forced low
//   clear_i                   - synchronous flush of FIFOs, counters and FSM
//   {a,b,c}_data_i/_valid_i   - operand stream inputs
//   {a,b,c}_ready_o           - operand stream back-pressure
//   op_data_o/op_valid_o      - joined operand beat {c,b,a}
//   op_ready_i                - engine accepts the beat
//   op_last_o                 - final beat of the job
//   ctrl_i                    - start pulse and job length
//   flags_o                   - busy, done, cnt, stall_cnt
// -----------------------------------------------------------------------------
module mac_operand_aligner
    import mac_package::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned CNT_WIDTH  = ALIGNER_CNT_W
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    test_mode_i,
    input  logic                    enable_i,
    input  logic                    clear_i,

    input  logic [DATA_WIDTH-1:0]   a_data_i,
    input  logic                    a_valid_i,
    output logic                    a_ready_o,

    input  logic [DATA_WIDTH-1:0]   b_data_i,
    input  logic                    b_valid_i,
    output logic                    b_ready_o,

    input  logic [DATA_WIDTH-1:0]   c_data_i,
    input  logic                    c_valid_i,
    output logic                    c_ready_o,

    output logic [3*DATA_WIDTH-1:0] op_data_o,
    output logic                    op_valid_o,
    input  logic                    op_ready_i,
    output logic                    op_last_o,

    input  ctrl_aligner_t           ctrl_i,
    output flags_aligner_t          flags_o
);

    aligner_state_t        state_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [CNT_WIDTH-1:0]  len_q;
    logic                  done_q;
    logic                  busy_q;
    logic [CNT_WIDTH-1:0]  stall_cnt;

    logic [DATA_WIDTH-1:0] a_head, b_head, c_head;
    logic                  a_full, b_full, c_full;
    logic                  a_empty, b_empty, c_empty;
    logic                  op_valid;
    logic                  op_hs;
    logic                  last_beat;
    logic                  start_ok;

    logic                  unused_test_mode;
    assign unused_test_mode = test_mode_i;

    // Ready is also gated by rst_ni so the streams see no acceptance while the
    // block is held in reset.
    assign a_ready_o = !a_full && enable_i && rst_ni;
    assign b_ready_o = !b_full && enable_i && rst_ni;
    assign c_ready_o = !c_full && enable_i && rst_ni;

    mac_aligner_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) i_fifo_a (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .enable_i (enable_i),
        .clear_i  (clear_i),
        .push_i   (a_valid_i && a_ready_o),
        .data_i   (a_data_i),
        .pop_i    (op_hs),
        .data_o   (a_head),
        .full_o   (a_full),
        .empty_o  (a_empty)
    );

    mac_aligner_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) i_fifo_b (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .enable_i (enable_i),
        .clear_i  (clear_i),
        .push_i   (b_valid_i && b_ready_o),
        .data_i   (b_data_i),
        .pop_i    (op_hs),
        .data_o   (b_head),
        .full_o   (b_full),
        .empty_o  (b_empty)
    );

    mac_aligner_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) i_fifo_c (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .enable_i (enable_i),
        .clear_i  (clear_i),
        .push_i   (c_valid_i && c_ready_o),
        .data_i   (c_data_i),
        .pop_i    (op_hs),
        .data_o   (c_head),
        .full_o   (c_full),
        .empty_o  (c_empty)
    );

    // A beat exists only when every operand is present; all three FIFOs are
    // popped together by the single handshake, so pairing can never slip.
    assign op_valid   = (state_q == RUN) && !a_empty && !b_empty && !c_empty && enable_i;
    assign op_hs      = op_valid && op_ready_i;
    assign last_beat  = (cnt_q == (len_q - CNT_WIDTH'(1)));
    assign start_ok   = (state_q == IDLE) && ctrl_i.start;

    assign op_valid_o = op_valid;
    assign op_last_o  = op_valid && last_beat;
    assign op_data_o  = op_valid ? {c_head, b_head, a_head} : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else if (enable_i) begin
            if (clear_i) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                done_q  <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (ctrl_i.start) begin
                            len_q  <= CNT_WIDTH'(ctrl_i.len);
                            cnt_q  <= '0;
                            busy_q <= 1'b1;
                            // A zero-length job completes without any beat.
                            if (ctrl_i.len == '0) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= RUN;
                            end
                        end
                    end
                    RUN: begin
                        if (op_hs) begin
                            cnt_q <= cnt_q + CNT_WIDTH'(1);
                            if (last_beat) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef MAC_ALIGNER_STATS_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else if (enable_i) begin
            if (clear_i || start_ok) begin
                stall_cnt_q <= '0;
            end else if ((state_q == RUN) && op_valid && !op_ready_i && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
    assign stall_cnt       = '0;
`endif

    assign flags_o.busy      = busy_q;
    assign flags_o.done      = done_q;
    assign flags_o.cnt       = ALIGNER_CNT_W'(cnt_q);
    assign flags_o.stall_cnt = ALIGNER_CNT_W'(stall_cnt);

endmodule : mac_operand_aligner

// File: tb/tb_mac_operand_aligner.sv
module tb_mac_operand_aligner;
    import mac_package::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, test_mode, enable, clear;
    logic [31:0] a_data, b_data, c_data;
    logic        a_valid, b_valid, c_valid;
    logic        a_ready, b_ready, c_ready;
    logic [95:0] op_data;
    logic        op_valid, op_ready, op_last;
    ctrl_aligner_t  ctrl;
    flags_aligner_t flags;

    mac_operand_aligner #(
        .DATA_WIDTH (32),
        .FIFO_DEPTH (2),
        .CNT_WIDTH  (16)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .test_mode_i (test_mode),
        .enable_i    (enable),
        .clear_i     (clear),
        .a_data_i    (a_data),
        .a_valid_i   (a_valid),
        .a_ready_o   (a_ready),
        .b_data_i    (b_data),
        .b_valid_i   (b_valid),
        .b_ready_o   (b_ready),
        .c_data_i    (c_data),
        .c_valid_i   (c_valid),
        .c_ready_o   (c_ready),
        .op_data_o   (op_data),
        .op_valid_o  (op_valid),
        .op_ready_i  (op_ready),
        .op_last_o   (op_last),
        .ctrl_i      (ctrl),
        .flags_o     (flags)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mkd(input logic [3:0] tag, input int idx);
        return {tag, 28'(idx)};
    endfunction

    function automatic logic [95:0] beat(input int idx);
        return {mkd(4'hC, idx), mkd(4'hB, idx), mkd(4'hA, idx)};
    endfunction

    // ---------------- behavioural model + compare process ----------------
    logic [31:0] qa[$], qb[$], qc[$];
    bit          m_run, m_done;
    int          m_cnt, m_len, m_stall;
    logic        e_ra, e_rb, e_rc, e_valid, e_last;
    logic [95:0] e_data;
    logic [95:0] obs[$];
    int          n_last = 0, last_cyc = -1, done_cyc = -1, cyc = 0;

    initial begin : compare
        bit hs;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                qa.delete(); qb.delete(); qc.delete();
                m_run = 0; m_done = 0; m_cnt = 0; m_stall = 0;
                e_ra = 0; e_rb = 0; e_rc = 0; e_valid = 0; e_last = 0; e_data = '0;
            end else begin
                e_ra    = enable && (qa.size() < 2);
                e_rb    = enable && (qb.size() < 2);
                e_rc    = enable && (qc.size() < 2);
                e_valid = enable && m_run && qa.size() > 0 && qb.size() > 0 && qc.size() > 0;
                e_data  = e_valid ? {qc[0], qb[0], qa[0]} : 96'h0;
                e_last  = e_valid && (m_cnt == m_len - 1);
            end
            chk("a_ready", a_ready, e_ra);
            chk("b_ready", b_ready, e_rb);
            chk("c_ready", c_ready, e_rc);
            chk("op_valid", op_valid, e_valid);
            chk("op_data", op_data, e_data);
            chk("op_last", op_last, e_last);
            chk("busy", flags.busy, m_run || m_done);
            chk("done", flags.done, m_done);
            chk("cnt", flags.cnt, 128'(m_cnt));
`ifdef MAC_ALIGNER_STATS_EN
            chk("stall_cnt", flags.stall_cnt, 128'(m_stall));
`else
            chk("stall_cnt", flags.stall_cnt, 128'(0));
`endif
            if (op_valid && op_ready) begin
                obs.push_back(op_data);
                if (op_last) begin n_last++; last_cyc = cyc; end
            end
            if (flags.done) done_cyc = cyc;

            @(posedge clk);
            if (rst_n && enable) begin
                if (clear) begin
                    qa.delete(); qb.delete(); qc.delete();
                    m_run = 0; m_done = 0; m_cnt = 0; m_stall = 0;
                end else begin
                    hs = e_valid && op_ready;
                    if (hs) begin void'(qa.pop_front()); void'(qb.pop_front()); void'(qc.pop_front()); end
                    if (a_valid && e_ra) qa.push_back(a_data);
                    if (b_valid && e_rb) qb.push_back(b_data);
                    if (c_valid && e_rc) qc.push_back(c_data);
                    if (m_done) begin
                        m_done = 0;
                    end else if (!m_run) begin
                        if (ctrl.start) begin
                            m_len = int'(ctrl.len); m_cnt = 0; m_stall = 0;
                            if (m_len == 0) m_done = 1; else m_run = 1;
                        end
                    end else begin
                        if (e_valid && !op_ready && m_stall < 65535) m_stall++;
                        if (hs) begin
                            m_cnt++;
                            if (m_cnt == m_len) begin m_run = 0; m_done = 1; end
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers (called at posedge + 1) ----------------
    task automatic drive(input int s, input logic v, input logic [31:0] d);
        case (s)
            0: begin a_valid = v; a_data = d; end
            1: begin b_valid = v; b_data = d; end
            default: begin c_valid = v; c_data = d; end
        endcase
    endtask

    function automatic logic rdy(input int s);
        case (s)
            0: return a_ready;
            1: return b_ready;
            default: return c_ready;
        endcase
    endfunction

    task automatic send(input int s, input int n, input int first, input int delay);
        int k = 0;
        int guard = 0;
        logic r;
        logic [3:0] tag;
        tag = (s == 0) ? 4'hA : (s == 1) ? 4'hB : 4'hC;
        if (delay > 0) begin repeat (delay) @(posedge clk); #1; end
        while (k < n && guard < 300) begin
            drive(s, 1'b1, mkd(tag, first + k));
            @(negedge clk); r = rdy(s);
            @(posedge clk); #1;
            if (r) k++;
            guard++;
        end
        drive(s, 1'b0, 32'h0);
        if (guard >= 300) chk("send_timeout", 0, 1);
    endtask

    task automatic pulse_start(input int l);
        ctrl.start = 1'b1; ctrl.len = 16'(l);
        @(posedge clk); #1;
        ctrl.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int g = 0;
        while (!flags.done && g < 200) begin @(negedge clk); g++; end
        chk(name, flags.done, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_beats(input int target);
        int g = 0;
        while (obs.size() < target && g < 200) begin @(posedge clk); #1; g++; end
        if (g >= 200) chk("beat_wait_timeout", 0, 1);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin : stim
        int bo;
        logic [95:0] held;
        logic [15:0] hcnt;
        rst_n = 0; test_mode = 0; enable = 1; clear = 0;
        a_data = 0; b_data = 0; c_data = 0; a_valid = 0; b_valid = 0; c_valid = 0;
        op_ready = 0; ctrl = '0;
        #2;
        chk("rst_busy", flags.busy, 0);
        chk("rst_ready_a", a_ready, 0);
        chk("rst_valid", op_valid, 0);
        repeat (2) @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;

        // len=4, all streams continuous, engine always ready
        op_ready = 1; bo = obs.size();
        fork
            send(0, 4, 0, 0);
            send(1, 4, 0, 0);
            send(2, 4, 0, 0);
            pulse_start(4);
        join
        wait_done("s1_done");
        chk("s1_beats", obs.size() - bo, 4);
        chk("s1_beat0", obs[bo], 96'hC0000000_B0000000_A0000000);
        chk("s1_beat3", obs[bo + 3], 96'hC0000003_B0000003_A0000003);
        chk("s1_lasts", n_last, 1);
        chk("s1_done_after_last", done_cyc - last_cyc, 1);
        chk("s1_cnt", flags.cnt, 4);

        // b delayed 3 cycles: a/c fill up, no beat until b arrives
        bo = obs.size();
        pulse_start(3);
        fork
            send(0, 3, 16, 0);
            send(2, 3, 16, 0);
            send(1, 3, 16, 3);
            begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                chk("s2_a_full_ready", a_ready, 0);
                chk("s2_c_full_ready", c_ready, 0);
                chk("s2_no_beat", op_valid, 0);
            end
        join
        wait_done("s2_done");
        chk("s2_beats", obs.size() - bo, 3);
        for (int i = 0; i < 3; i++) chk("s2_pair", obs[bo + i], beat(16 + i));

        // len=8 with engine stalled 5 cycles after 3 beats
        bo = obs.size();
        fork
            send(0, 8, 32, 0);
            send(1, 8, 32, 0);
            send(2, 8, 32, 0);
            pulse_start(8);
            begin
                wait_beats(bo + 3);
                op_ready = 0;
                @(negedge clk); held = op_data; hcnt = flags.cnt;
                chk("s3_cnt_at_stall", hcnt, 3);
                chk("s3_data_at_stall", held, 96'hC0000023_B0000023_A0000023);
                repeat (4) begin
                    @(negedge clk);
                    chk("s3_hold_data", op_data, held);
                    chk("s3_hold_cnt", flags.cnt, hcnt);
                end
                @(posedge clk); #1;
                op_ready = 1;
            end
        join
        wait_done("s3_done");
        chk("s3_beats", obs.size() - bo, 8);
`ifdef MAC_ALIGNER_STATS_EN
        chk("s3_stall_cnt", flags.stall_cnt, 5);
`else
        chk("s3_stall_cnt", flags.stall_cnt, 0);
`endif

        // len=0: done on the next cycle, no beat
        bo = obs.size();
        pulse_start(0);
        @(negedge clk);
        chk("s4_done", flags.done, 1);
        chk("s4_valid", op_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("s4_done_once", flags.done, 0);
        chk("s4_beats", obs.size() - bo, 0);
        @(posedge clk); #1;

        // clear at cnt=2 of len=6, then a normal len=2 job
        bo = obs.size();
        fork
            send(0, 4, 48, 0);
            send(1, 4, 48, 0);
            send(2, 4, 48, 0);
            pulse_start(6);
            begin wait_beats(bo + 2); op_ready = 0; end
        join
        chk("s5_cnt_before_clear", flags.cnt, 2);
        clear = 1;
        @(posedge clk); #1;
        clear = 0;
        @(negedge clk);
        chk("s5_busy", flags.busy, 0);
        chk("s5_cnt", flags.cnt, 0);
        chk("s5_fifo_empty", a_ready, 1);
        op_ready = 1;
        repeat (4) @(posedge clk); #1;
        chk("s5_no_more_beats", obs.size() - bo, 2);
        bo = obs.size();
        fork
            send(0, 2, 64, 0);
            send(1, 2, 64, 0);
            send(2, 2, 64, 0);
            pulse_start(2);
        join
        wait_done("s5_second_done");
        chk("s5_second_beats", obs.size() - bo, 2);
        chk("s5_second_beat1", obs[bo + 1], 96'hC0000041_B0000041_A0000041);

        // reset mid-job
        bo = obs.size();
        op_ready = 0;
        pulse_start(4);
        fork
            send(0, 2, 80, 0);
            send(1, 2, 80, 0);
            send(2, 2, 80, 0);
        join
        rst_n = 0;
        #1;
        chk("s6_rst_valid", op_valid, 0);
        chk("s6_rst_ready", a_ready, 0);
        chk("s6_rst_busy", flags.busy, 0);
        chk("s6_rst_data", op_data, 0);
        repeat (2) @(posedge clk); #1;
        rst_n = 1;
        op_ready = 1;
        repeat (6) @(posedge clk); #1;
        chk("s6_silent", obs.size() - bo, 0);
        chk("s6_silent_valid", op_valid, 0);

        // enable low mid-job freezes everything
        bo = obs.size();
        pulse_start(2);
        enable = 0;
        fork
            send(0, 2, 96, 0);
            send(1, 2, 96, 0);
            send(2, 2, 96, 0);
            begin
                @(negedge clk);
                chk("s7_en_ready", a_ready, 0);
                chk("s7_en_busy", flags.busy, 1);
                repeat (2) @(posedge clk); #1;
                enable = 1;
            end
        join
        wait_done("s7_done");
        chk("s7_beat0", obs[bo], 96'hC0000060_B0000060_A0000060);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mac_operand_aligner
